fetch_queue: RTL

Instruction fetch front end for the single-cycle MIPS core: owns the fetch PC, issues word reads to the instruction memory bank over a req/ack handshake, and buffers returned instructions in a small in-order prefetch queue. Decode drains the queue through a valid/ready interface. Taken branches and jumps redirect the fetch PC and flush all buffered and in-flight instructions. PCs are word addresses (increment by 1), matching the core's 8-bit PC.

---
 rtl/fetch_queue.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch front end with an in-order prefetch queue.
//
// Owns the fetch PC (word address), issues one outstanding word read at a time
// to instruction memory over a req/ack handshake, and buffers returned words
// together with their PC. Decode drains the head through valid/ready. A
// redirect (taken branch/jump) flushes the queue and restarts fetch; a request
// already in flight when the redirect arrives is completed and its data dropped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/imem_addr  registered read request and word address
//   imem_ack/imem_rdata memory completion and returned instruction word
//   instr_valid/instr/instr_pc/instr_ready  queue head to decode
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   count               queue occupancy
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic                req_nx;

  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;

  logic                push, pop;
  logic [CNT_W-1:0]    count_nx;
  logic                has_room;

  // Redirect outranks both push and pop; the queue is simply cleared.
  always_comb begin
    pop      = (count != '0) && instr_ready && !redirect;
    push     = (state == WAIT) && imem_ack && !redirect;
    count_nx = count + CNT_W'(push) - CNT_W'(pop);
    has_room = (count_nx < CNT_W'(DEPTH));
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_nx      = imem_req;
    addr_nx     = imem_addr;
    if (redirect) begin
      fetch_pc_nx = redirect_pc;
      // An ack this cycle completes the old request, so the new one can start
      // immediately; otherwise the old request must run out in DROP.
      if (state == IDLE || imem_ack) begin
        state_nx = WAIT;
        req_nx   = 1'b1;
        addr_nx  = redirect_pc;
      end else begin
        state_nx = DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (has_room) begin
            state_nx = WAIT;
            req_nx   = 1'b1;
            addr_nx  = fetch_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc_nx = fetch_pc + ADDR_W'(1);
            addr_nx     = fetch_pc + ADDR_W'(1);
            if (has_room) begin
              req_nx = 1'b1;
            end else begin
              state_nx = IDLE;
              req_nx   = 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_nx = WAIT;
            req_nx   = 1'b1;
            addr_nx  = fetch_pc;
          end
        end
        default: begin
          state_nx = IDLE;
          req_nx   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]   <= fetch_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nx;
    end
  end

  always_comb begin
    instr_valid = (count != '0);
    instr       = data_q[rd_ptr];
    instr_pc    = pc_q[rd_ptr];
  end

endmodule
